// File: rtl/hw_accel_ctrl_pkg.sv
// hw_accel_ctrl_pkg: register map, CTRL/STATUS bit positions, FSM
// state encoding and default ID shared by the accelerator controller.
package hw_accel_ctrl_pkg;

  // Register offsets as word indices (byte address bits [4:2]).
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_MODE    = 3'd2;
  localparam logic [2:0] REG_LEN     = 3'd3;
  localparam logic [2:0] REG_TIMEOUT = 3'd4;
  localparam logic [2:0] REG_CYCLES  = 3'd5;
  localparam logic [2:0] REG_ID      = 3'd6;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERROR   = 2;
  localparam int ST_TIMEOUT = 3;
  localparam int ST_OVERRUN = 4;

  localparam logic [31:0] DEFAULT_ID = 32'hACCE0001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_ABORT  = 2'd3
  } state_e;

endpackage

// File: rtl/hw_accel_ctrl_if.sv
// hw_accel_ctrl_if: user register bus (write strobe/addr/data,
// read strobe/addr, registered read data/valid); master drives, slave responds.
interface hw_accel_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  usr_we;
  logic [ADDR_WIDTH-1:0] usr_waddr;
  logic [DATA_WIDTH-1:0] usr_wdata;
  logic                  usr_re;
  logic [ADDR_WIDTH-1:0] usr_raddr;
  logic [DATA_WIDTH-1:0] usr_rdata;
  logic                  usr_rvalid;

  modport master (
    output usr_we, usr_waddr, usr_wdata, usr_re, usr_raddr,
    input  usr_rdata, usr_rvalid
  );

  modport slave (
    input  usr_we, usr_waddr, usr_wdata, usr_re, usr_raddr,
    output usr_rdata, usr_rvalid
  );
endinterface

// File: rtl/hw_accel_watchdog.sv
// hw_accel_watchdog: saturating run-cycle counter with optional limit compare.
// Ports: clk/rst, clear/enable/limit in; count/expired out (HW_ACCEL_TIMEOUT_EN).
module hw_accel_watchdog (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] limit,
  output logic [31:0] count,
  output logic        expired
);
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) count_d = '0;
    else if (enable && count_q != '1) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

`ifdef HW_ACCEL_TIMEOUT_EN
  // A zero limit disables the watchdog.
  assign expired = (limit != '0) && (count_q == limit);
`else
  logic unused_limit;
  assign unused_limit = ^limit;
  assign expired = 1'b0;
`endif
endmodule

// File: rtl/hw_accel_ctrl.sv
// hw_accel_ctrl: register file plus IDLE/LAUNCH/RUN/ABORT launch FSM.
// Ports: axi_aclk/axi_reset, usr bus, accel_* handshake, irq. Option HW_ACCEL_TIMEOUT_EN.
module hw_accel_ctrl
  import hw_accel_ctrl_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = DEFAULT_ID
) (
  input  logic           axi_aclk,
  input  logic           axi_reset,
  hw_accel_ctrl_if.slave usr,
  output logic           accel_start,
  output logic           accel_abort,
  output logic [3:0]     accel_mode,
  output logic [15:0]    accel_len,
  input  logic           accel_done,
  input  logic           accel_error,
  output logic           irq
);
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [2:0]  wsel, rsel;
  logic        wr_ctrl, start_wr, abort_wr;
  logic [4:1]  w1c;

  assign waddr = usr.usr_waddr;
  assign raddr = usr.usr_raddr;
  assign wdata = usr.usr_wdata;
  assign wsel  = waddr[4:2];
  assign rsel  = raddr[4:2];

  // Address bits outside [4:2] and spare data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{waddr, raddr, wdata};

  assign wr_ctrl  = usr.usr_we && (wsel == REG_CTRL);
  assign start_wr = wr_ctrl && wdata[CTRL_START];
  assign abort_wr = wr_ctrl && wdata[CTRL_ABORT];
  assign w1c = (usr.usr_we && wsel == REG_STATUS) ? wdata[4:1] : 4'd0;

  state_e      state_q, state_d;
  logic        ev_launch, ev_done, ev_err, ev_to, ev_ovr;
  logic        busy, expired;
  logic [31:0] cycles, tmo_val;

  logic        irq_en_q, irq_en_d;
  logic [3:0]  mode_q, mode_d, amode_q, amode_d;
  logic [15:0] len_q, len_d, alen_q, alen_d;
  logic [4:1]  sts_q, sts_d;
  logic        irq_q, irq_d, rvalid_q;
  logic [31:0] rd_val, rdata_q, rdata_d;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Completion in RUN outranks an abort write or watchdog expiry.
  always_comb begin
    state_d   = state_q;
    ev_launch = 1'b0;
    ev_done   = 1'b0;
    ev_err    = 1'b0;
    ev_to     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          if (len_q != '0) begin
            state_d   = S_LAUNCH;
            ev_launch = 1'b1;
          end else begin
            ev_done = 1'b1;
          end
        end
      end
      S_LAUNCH: state_d = abort_wr ? S_ABORT : S_RUN;
      S_RUN: begin
        if (accel_done) begin
          state_d = S_IDLE;
          ev_done = 1'b1;
          ev_err  = accel_error;
        end else if (abort_wr || expired) begin
          state_d = S_ABORT;
          ev_to   = expired;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ev_ovr = start_wr && (state_q != S_IDLE);
  end

  always_comb begin
    accel_start = (state_q == S_LAUNCH);
    accel_abort = (state_q == S_ABORT);
    busy        = (state_q != S_IDLE);
  end

  hw_accel_watchdog u_wdog (
    .clk     (axi_aclk),
    .rst     (axi_reset),
    .clear   (ev_launch),
    .enable  (state_q == S_LAUNCH || state_q == S_RUN),
    .limit   (tmo_val),
    .count   (cycles),
    .expired (expired)
  );

`ifdef HW_ACCEL_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  always_comb begin
    tmo_d = tmo_q;
    if (usr.usr_we && wsel == REG_TIMEOUT) tmo_d = wdata;
  end
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) tmo_q <= '0;
    else           tmo_q <= tmo_d;
  end
  assign tmo_val = tmo_q;
`else
  assign tmo_val = '0;
`endif

  always_comb begin
    irq_en_d = irq_en_q;
    mode_d   = mode_q;
    len_d    = len_q;
    amode_d  = amode_q;
    alen_d   = alen_q;
    if (wr_ctrl) irq_en_d = wdata[CTRL_IRQ_EN];
    if (usr.usr_we && wsel == REG_MODE) mode_d = wdata[3:0];
    if (usr.usr_we && wsel == REG_LEN)  len_d  = wdata[15:0];
    if (ev_launch) begin
      amode_d = mode_q;
      alen_d  = len_q;
    end
    // Hardware set wins over a same-cycle W1C.
    sts_d = (sts_q & ~w1c) | {ev_ovr, ev_to, ev_err, ev_done};
    irq_d = irq_en_q &
            (sts_q[ST_DONE] | sts_q[ST_ERROR] | sts_q[ST_TIMEOUT]);
  end

  always_comb begin
    rd_val = '0;
    unique case (rsel)
      REG_CTRL:    rd_val = {29'd0, irq_en_q, 2'b00};
      REG_STATUS:  rd_val = {27'd0, sts_q, busy};
      REG_MODE:    rd_val = {28'd0, mode_q};
      REG_LEN:     rd_val = {16'd0, len_q};
      REG_TIMEOUT: rd_val = tmo_val;
      REG_CYCLES:  rd_val = cycles;
      REG_ID:      rd_val = ID_VALUE;
      default:     rd_val = '0;
    endcase
    rdata_d = usr.usr_re ? rd_val : '0;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      irq_en_q <= 1'b0;
      mode_q   <= '0;
      len_q    <= '0;
      amode_q  <= '0;
      alen_q   <= '0;
      sts_q    <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      irq_en_q <= irq_en_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      amode_q  <= amode_d;
      alen_q   <= alen_d;
      sts_q    <= sts_d;
      irq_q    <= irq_d;
      rvalid_q <= usr.usr_re;
      rdata_q  <= rdata_d;
    end
  end

  assign accel_mode     = amode_q;
  assign accel_len      = alen_q;
  assign irq            = irq_q;
  assign usr.usr_rvalid = rvalid_q;
  assign usr.usr_rdata  = rdata_q;
endmodule
